// File: rtl/mem_bus_arbiter_pkg.sv
// Shared constants for the SoC memory arbiter: master indices and the fetch starvation default.
package mem_bus_arbiter_pkg;

  localparam logic [1:0] MST_LOAD = 2'd0;
  localparam logic [1:0] MST_LSU  = 2'd1;
  localparam logic [1:0] MST_IFU  = 2'd2;
  localparam logic [1:0] MST_NONE = 2'd3;

  localparam int NUM_MST          = 3;
  localparam int STARVE_LIMIT_DEF = 4;

  function automatic logic [NUM_MST-1:0] idx_to_onehot(input logic [1:0] idx);
    if (idx == MST_NONE) return '0;
    return NUM_MST'(3'b001 << idx);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_prio.sv
// Combinational 3-way fixed-priority picker; rotate_i lifts M2 to the top (M2 > M0 > M1).
module prio_arb3 (
  input  logic [2:0] req_i,
  input  logic       rotate_i,
  output logic [2:0] gnt_o
);

  always_comb begin
    gnt_o = 3'b000;
    if (rotate_i && req_i[2]) gnt_o = 3'b100;
    else if (req_i[0])        gnt_o = 3'b001;
    else if (req_i[1])        gnt_o = 3'b010;
    else if (req_i[2])        gnt_o = 3'b100;
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Single-port memory arbiter for loader (M0), load/store (M1) and fetch (M2) with a
// one-cycle registered read response and a fetch anti-starvation counter.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [2:0]          m_req,
  input  logic [2:0]          m_we,
  input  logic [3*AW-1:0]     m_addr,
  input  logic [3*DW-1:0]     m_wdata,
  input  logic [3*DW/8-1:0]   m_be,
  output logic [2:0]          m_gnt,
  output logic [2:0]          m_rvalid,
  output logic [DW-1:0]       m_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  output logic [DW/8-1:0]     mem_be,
  input  logic [DW-1:0]       mem_rdata
);

  localparam int BW = DW / 8;

  logic [3:0] starve_cnt_q, starve_cnt_d;
  logic [1:0] rd_owner_q, rd_owner_d;
  logic       starve_hit;

  assign starve_hit = (starve_cnt_q == 4'(STARVE_LIMIT));

  prio_arb3 u_prio_arb3 (
    .req_i    (m_req),
    .rotate_i (starve_hit),
    .gnt_o    (m_gnt)
  );

  // m_gnt is one-hot, so at most one iteration selects the memory fields.
  always_comb begin
    mem_en     = |m_gnt;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_be     = '0;
    rd_owner_d = MST_NONE;
    for (int i = 0; i < NUM_MST; i++) begin
      if (m_gnt[i]) begin
        mem_we    = m_we[i];
        mem_addr  = m_addr[i*AW +: AW] >> 2;
        mem_wdata = m_wdata[i*DW +: DW];
        mem_be    = m_be[i*BW +: BW];
        if (!m_we[i]) rd_owner_d = 2'(i);
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!m_req[MST_IFU] || m_gnt[MST_IFU]) starve_cnt_d = 4'd0;
    else if (!starve_hit)                  starve_cnt_d = starve_cnt_q + 4'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_q <= 4'd0;
      rd_owner_q   <= MST_NONE;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Read data is only meaningful in the cycle after the grant; gate it to zero otherwise.
  assign m_rvalid = idx_to_onehot(rd_owner_q);
  assign m_rdata  = (|m_rvalid) ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: memory model, reference memory and response scoreboard.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    m_req, m_we;
  logic [95:0]   m_addr, m_wdata;
  logic [11:0]   m_be;
  logic [2:0]    m_gnt, m_rvalid;
  logic [31:0]   m_rdata;
  logic          mem_en, mem_we;
  logic [31:0]   mem_addr, mem_wdata;
  logic [3:0]    mem_be;
  logic [31:0]   mem_rdata;

  logic [31:0]   addr[3];
  logic [31:0]   wdat[3];
  logic [3:0]    bsel[3];

  logic [31:0]   mem_arr [0:15];
  logic [31:0]   ref_mem [0:15];

  typedef struct {
    logic [2:0]  rv;
    logic [31:0] data;
  } rsp_t;
  rsp_t sb_q[$];

  int checks = 0;
  int errors = 0;

  assign m_addr  = {addr[2], addr[1], addr[0]};
  assign m_wdata = {wdat[2], wdat[1], wdat[0]};
  assign m_be    = {bsel[2], bsel[1], bsel[0]};

  always #5 clk = ~clk;

  mem_bus_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .m_req     (m_req),
    .m_we      (m_we),
    .m_addr    (m_addr),
    .m_wdata   (m_wdata),
    .m_be      (m_be),
    .m_gnt     (m_gnt),
    .m_rvalid  (m_rvalid),
    .m_rdata   (m_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_be    (mem_be),
    .mem_rdata (mem_rdata)
  );

  // Synchronous single-port memory, read data valid the cycle after the access.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) begin
        for (int b = 0; b < 4; b++)
          if (mem_be[b]) mem_arr[mem_addr[3:0]][b*8 +: 8] <= mem_wdata[b*8 +: 8];
      end else begin
        mem_rdata <= mem_arr[mem_addr[3:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One bus cycle: check grant, due response and memory port, then advance past the edge.
  task automatic cycle_check(input logic [2:0] exp_gnt);
    int   idx;
    rsp_t e;
    logic [31:0] w;
    @(negedge clk);
    chk("gnt", m_gnt, exp_gnt);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
    end else begin
      e.rv = 3'b000;
      e.data = 32'h0;
    end
    chk("rvalid", m_rvalid, e.rv);
    chk("rdata", m_rdata, e.data);
    chk("mem_en", mem_en, |exp_gnt);
    if (exp_gnt != 3'b000) begin
      idx = exp_gnt[0] ? 0 : (exp_gnt[1] ? 1 : 2);
      chk("mem_addr", mem_addr, addr[idx] >> 2);
      chk("mem_we", mem_we, m_we[idx]);
      if (m_we[idx]) begin
        chk("mem_wdata", mem_wdata, wdat[idx]);
        chk("mem_be", mem_be, bsel[idx]);
        w = ref_mem[addr[idx][5:2]];
        for (int b = 0; b < 4; b++)
          if (bsel[idx][b]) w[b*8 +: 8] = wdat[idx][b*8 +: 8];
        ref_mem[addr[idx][5:2]] = w;
      end else begin
        e.rv = exp_gnt;
        e.data = ref_mem[addr[idx][5:2]];
        sb_q.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      mem_arr[i] = 32'h1000_0000 + 32'(i * 16'h0101);
      ref_mem[i] = 32'h1000_0000 + 32'(i * 16'h0101);
    end
    mem_arr[4] = 32'hDEAD_BEEF;
    ref_mem[4] = 32'hDEAD_BEEF;
    mem_rdata = 32'h0;
    for (int i = 0; i < 3; i++) begin
      wdat[i] = 32'h0;
      bsel[i] = 4'h0;
    end
    addr[0] = 32'h0; addr[1] = 32'h4; addr[2] = 32'h10;

    // Reset held with all masters requesting
    rst_n = 1'b0; m_req = 3'b111; m_we = 3'b000;
    repeat (2) begin
      @(negedge clk);
      chk("rst_rvalid", m_rvalid, 3'b000);
      chk("rst_rdata", m_rdata, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle_check(3'b001);
    m_req = 3'b110; cycle_check(3'b010);
    m_req = 3'b100; cycle_check(3'b100);
    m_req = 3'b000; cycle_check(3'b000);
    cycle_check(3'b000);

    // Lone fetch read of word 4
    addr[2] = 32'h10; m_req = 3'b100; cycle_check(3'b100);
    m_req = 3'b000; cycle_check(3'b000);

    // M1 partial write collides with M2 read; then read back the written word
    addr[1] = 32'h8; wdat[1] = 32'h1234_5678; bsel[1] = 4'b0011; m_we = 3'b010;
    addr[2] = 32'h0; m_req = 3'b110; cycle_check(3'b010);
    m_req = 3'b100; cycle_check(3'b100);
    m_we = 3'b000; addr[2] = 32'h8; cycle_check(3'b100);
    m_req = 3'b000; cycle_check(3'b000);

    // Fetch starvation: four denials then a forced grant, twice
    addr[0] = 32'h0; addr[2] = 32'hC; m_req = 3'b101;
    for (int r = 0; r < 2; r++) begin
      repeat (4) cycle_check(3'b001);
      cycle_check(3'b100);
    end
    cycle_check(3'b001);
    m_req = 3'b000; cycle_check(3'b000);

    // Alternating M1/M2 reads, back to back
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0) begin
        addr[1] = 32'(i * 4); m_req = 3'b010; cycle_check(3'b010);
      end else begin
        addr[2] = 32'(i * 4); m_req = 3'b100; cycle_check(3'b100);
      end
    end
    m_req = 3'b000; cycle_check(3'b000);

    // Reset right after a read grant drops the response
    addr[1] = 32'h10; m_req = 3'b010; cycle_check(3'b010);
    rst_n = 1'b0; m_req = 3'b000;
    sb_q.delete();
    repeat (2) begin
      @(negedge clk);
      chk("rst2_rvalid", m_rvalid, 3'b000);
      chk("rst2_rdata", m_rdata, 32'h0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cycle_check(3'b000);
    cycle_check(3'b000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
